// File: rtl/regs_wb_pkg.sv
//==============================================================================
// Module      : regs_wb_pkg
// Description : Shared widths and named register numbers for the write-back
//               register file and the RegDst selector.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package regs_wb_pkg;
    localparam int unsigned REGS_DW  = 32;
    localparam int unsigned REGS_AW  = 5;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_RA   = 31;
endpackage

`default_nettype wire

// File: rtl/regs_wb_pend.sv
//==============================================================================
// Module      : regs_wb_pend
// Description : One-entry pending-write latch; captures a write-back each edge
//               and presents it for commit on the following edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regs_wb_pend
    import regs_wb_pkg::*;
#(
    parameter int DW = REGS_DW,
    parameter int AW = REGS_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wd,
    output logic          o_pend_v,
    output logic [AW-1:0] o_pend_a,
    output logic [DW-1:0] o_pend_d
);

    logic          r_v;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic          w_capture;

    // Writes to register zero are dropped here so they never reach the array.
    assign w_capture = i_we && (i_wa != AW'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= 1'b0;
            r_a <= '0;
            r_d <= '0;
        end else begin
            r_v <= w_capture;
            if (w_capture) begin
                r_a <= i_wa;
                r_d <= i_wd;
            end
        end
    end

    assign o_pend_v = r_v;
    assign o_pend_a = r_a;
    assign o_pend_d = r_d;

endmodule

`default_nettype wire

// File: rtl/regs_wb.sv
//==============================================================================
// Module      : regs_wb
// Description : MIPS write-back register file with a pending-write stage, two
//               combinational read ports and a debug read port.
//               Define REGS_BYPASS_EN to forward the pending write to rd_A/rd_B.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regs_wb
    import regs_wb_pkg::*;
#(
    parameter int DW = REGS_DW,
    parameter int AW = REGS_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra_A,
    input  logic [AW-1:0] ra_B,
    output logic [DW-1:0] rd_A,
    output logic [DW-1:0] rd_B,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic          commit,
    output logic [AW-1:0] commit_addr
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] r_mem [NREG];
    logic          w_pend_v;
    logic [AW-1:0] w_pend_a;
    logic [DW-1:0] w_pend_d;

    regs_wb_pend #(
        .DW (DW),
        .AW (AW)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .i_we     (we),
        .i_wa     (wa),
        .i_wd     (wd),
        .o_pend_v (w_pend_v),
        .o_pend_a (w_pend_a),
        .o_pend_d (w_pend_d)
    );

    // Reset discards any pending write; it never reaches the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_pend_v) begin
            r_mem[w_pend_a] <= w_pend_d;
        end
    end

    always_comb begin
        rd_A = '0;
        rd_B = '0;
        if (ra_A != AW'(REG_ZERO)) begin
            rd_A = r_mem[ra_A];
`ifdef REGS_BYPASS_EN
            if (w_pend_v && (w_pend_a == ra_A)) begin
                rd_A = w_pend_d;
            end
`endif
        end
        if (ra_B != AW'(REG_ZERO)) begin
            rd_B = r_mem[ra_B];
`ifdef REGS_BYPASS_EN
            if (w_pend_v && (w_pend_a == ra_B)) begin
                rd_B = w_pend_d;
            end
`endif
        end
    end

    assign dbg_data    = r_mem[dbg_addr];
    assign commit      = w_pend_v;
    assign commit_addr = w_pend_a;

endmodule

`default_nettype wire

// File: tb/tb_regs_wb.sv
//==============================================================================
// Module      : tb_regs_wb
// Description : Directed self-checking bench for regs_wb (bypass on or off).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regs_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [4:0]  ra_A = '0;
    logic [4:0]  ra_B = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] rd_A, rd_B, dbg_data;
    logic        commit;
    logic [4:0]  commit_addr;

    int n_total = 0;
    int n_bad   = 0;

`ifdef REGS_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    regs_wb u_dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .ra_A        (ra_A),
        .ra_B        (ra_B),
        .rd_A        (rd_A),
        .rd_B        (rd_B),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .commit      (commit),
        .commit_addr (commit_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset asserted from time zero
        #1;
        chk("rst_commit", {31'b0, commit}, 32'd0);
        chk("rst_caddr", {27'b0, commit_addr}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra_A = 5'(i); ra_B = 5'(i); dbg_addr = 5'(i);
            #1;
            chk($sformatf("rst_rdA%0d", i), rd_A, 32'd0);
            chk($sformatf("rst_rdB%0d", i), rd_B, 32'd0);
            chk($sformatf("rst_dbg%0d", i), dbg_data, 32'd0);
        end
        tick();
        rst = 1'b0;

        // Single write to r5
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra_A = 5'd5; dbg_addr = 5'd5;
        tick();
        we = 1'b0;
        #1;
        chk("w5_e1_commit", {31'b0, commit}, 32'd1);
        chk("w5_e1_caddr", {27'b0, commit_addr}, 32'd5);
        chk("w5_e1_rdA", rd_A, c_byp ? 32'hDEADBEEF : 32'd0);
        chk("w5_e1_dbg", dbg_data, 32'd0);
        tick();
        chk("w5_e2_rdA", rd_A, 32'hDEADBEEF);
        chk("w5_e2_dbg", dbg_data, 32'hDEADBEEF);
        chk("w5_e2_commit", {31'b0, commit}, 32'd0);

        // Write to r0 is discarded
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra_A = 5'd0; dbg_addr = 5'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("w0_commit%0d", i), {31'b0, commit}, 32'd0);
            chk($sformatf("w0_rdA%0d", i), rd_A, 32'd0);
            chk($sformatf("w0_dbg%0d", i), dbg_data, 32'd0);
        end
        we = 1'b0;

        // Back-to-back writes to r31
        we = 1'b1; wa = 5'd31; wd = 32'h1; ra_A = 5'd31; dbg_addr = 5'd31;
        tick();
        wd = 32'h2;
        tick();
        we = 1'b0;
        chk("b2b_e2_dbg", dbg_data, 32'h1);
        chk("b2b_e2_rdA", rd_A, c_byp ? 32'h2 : 32'h1);
        chk("b2b_e2_caddr", {27'b0, commit_addr}, 32'd31);
        tick();
        chk("b2b_e3_dbg", dbg_data, 32'h2);
        chk("b2b_e3_rdA", rd_A, 32'h2);

        // Reset drops a pending write to r7
        we = 1'b1; wa = 5'd7; wd = 32'h1234; dbg_addr = 5'd7; ra_B = 5'd5;
        tick();
        we = 1'b0;
        chk("rst7_pre_commit", {31'b0, commit}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst7_commit", {31'b0, commit}, 32'd0);
        chk("rst7_caddr", {27'b0, commit_addr}, 32'd0);
        chk("rst7_dbg", dbg_data, 32'd0);
        chk("rst7_rdB5", rd_B, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst7_post_dbg", dbg_data, 32'd0);
        chk("rst7_post_commit", {31'b0, commit}, 32'd0);

        // Dual read of r3 during a pending overwrite
        we = 1'b1; wa = 5'd3; wd = 32'h11111111;
        tick();
        we = 1'b0;
        tick();
        we = 1'b1; wd = 32'hA5A5A5A5; ra_A = 5'd3; ra_B = 5'd3; dbg_addr = 5'd3;
        #1;
        chk("r3_samecyc_rdA", rd_A, 32'h11111111);
        tick();
        we = 1'b0;
        chk("r3_pend_rdA", rd_A, c_byp ? 32'hA5A5A5A5 : 32'h11111111);
        chk("r3_pend_rdB", rd_B, c_byp ? 32'hA5A5A5A5 : 32'h11111111);
        chk("r3_pend_dbg", dbg_data, 32'h11111111);
        tick();
        chk("r3_done_rdA", rd_A, 32'hA5A5A5A5);
        chk("r3_done_rdB", rd_B, 32'hA5A5A5A5);
        ra_B = 5'd31;
        #1;
        chk("r31_rdB", rd_B, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
